word_packer: RTL and testbench
==============================

# word_packer

Downstream stage of the channel distributor. Accepts 12-bit channel words on a single-cycle write strobe, buffers them in a small synchronous FIFO, and packs each pair of words into three bytes for the byte-serial transmitter (UART/link framer) over a valid/ready handshake. Decouples bursty per-frame word arrival from the slower byte sink and flags data loss.

## Interface
- DEPTH, 16, FIFO depth in 12-bit words; power of two, ≥ 4
- ADDR_W, 4, log2(DEPTH)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- wData  in  12  channel word from distributor
- wrEn  in  1  write strobe, one cycle per word; wData valid in that cycle
- txData  out  8  byte to transmitter
- txValid  out  1  txData holds a valid byte
- txReady  in  1  transmitter accepts byte; transfer when txValid & txReady at a rising edge
- level  out  ADDR_W+1  words currently stored, 0..DEPTH
- full  out  1  level == DEPTH
- overflow  out  1  sticky; set when a write is dropped, cleared only by reset

## Operation
- Write: at an edge with wrEn=1, store wData at wrPtr, wrPtr++ (wraps mod DEPTH), unless full at that edge; then the word is dropped and overflow←1.
- Packing of pair (A = older, B = newer): byte0 = A[11:4], byte1 = {A[3:0], B[11:8]}, byte2 = B[7:0]; sent in that order.
- FSM states: IDLE, POP_B, BYTE0, BYTE1, BYTE2.
  - IDLE: if level ≥ 2: A←mem[rdPtr], rdPtr++ → POP_B; else stay. Single words wait indefinitely.
  - POP_B: B←mem[rdPtr], rdPtr++, txData←byte0, txValid←1 → BYTE0.
  - BYTE0: on txReady: txData←byte1 → BYTE1.
  - BYTE1: on txReady: txData←byte2 → BYTE2.
  - BYTE2: on txReady: txValid←0 → IDLE.
- txValid, once raised, stays high and txData stable until accepted; no byte is ever withdrawn.
- level = words written − words popped; a write and a pop at the same edge leave level unchanged. Full test uses level before the edge, i.e. a pop at the same edge does not free space for that write.

## Timing
- Reset values: txData=0, txValid=0, level=0, full=0, overflow=0, pointers 0, FSM IDLE, A/B=0.
- Second word written at edge N → A popped at N+1 → txValid=1 with byte0 after N+2.
- With txReady held high, three bytes transfer on consecutive edges N+3, N+4, N+5; txValid=0 after N+5; next pair earliest popped at N+6 (pair throughput 5 cycles min).
- txReady low stalls in the current BYTEx state indefinitely; writes continue meanwhile.
- Reset mid-pair: partial pair discarded, txValid drops immediately, buffered words lost.
- Pointer wrap: DEPTH writes then reads return words in order across the wrap boundary.

## Structure
- Shared package: WORD_W=12, BYTE_W=8, FSM state encodings (3-bit).
- Sub-module word_fifo: storage, wrPtr/rdPtr, level, full, drop detection; combinational read of mem[rdPtr], pop input. word_packer holds FSM, A/B registers, byte mux, overflow.

## Test plan
- Write 0xABC then 0x123, txReady=1 → bytes 0xAB, 0xC1, 0x23 on consecutive edges, txValid low after.
- Single write 0x5A5 only → txValid stays 0, level=1 indefinitely.
- Pair 0xFFF,0x000 with txReady=0 for 10 cycles after txValid rises → txData holds 0xFF, no pointer motion; then txReady=1 → 0xFF, 0xF0, 0x00.
- 17 writes with txReady=0 and sink stalled before any pop (DEPTH=16) → full=1, overflow=1, 17th word absent from output stream.
- 40 writes of incrementing values interleaved with random txReady → byte stream decodes to 0..39 in order across pointer wrap, overflow=0.
- Assert reset during BYTE1 → all outputs at reset values next cycle, no further bytes until two new writes.

Source files
------------

// File: rtl/word_packer_pkg.sv
// Shared definitions for the word packer: word/byte widths, packer FSM
// state encoding and the pair-to-byte split used by the byte mux.
package word_packer_pkg;

  localparam int WORD_W = 12;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP_B = 3'd1,
    BYTE0 = 3'd2,
    BYTE1 = 3'd3,
    BYTE2 = 3'd4
  } packState_e;

  // Two 12-bit words form one 24-bit group; idx 0 is the most significant byte.
  function automatic logic [BYTE_W-1:0] pairByte(input logic [WORD_W-1:0] wordA,
                                                 input logic [WORD_W-1:0] wordB,
                                                 input logic [1:0]        idx);
    logic [2*WORD_W-1:0] pair;
    pair = {wordA, wordB};
    case (idx)
      2'd0:    return pair[23:16];
      2'd1:    return pair[15:8];
      default: return pair[7:0];
    endcase
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with occupancy count. Reads are combinational
// from the head entry; a write while full is dropped and reported on drop.
module word_fifo
  import word_packer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] wData,
  input  logic              wrEn,
  input  logic              pop,
  output logic [WORD_W-1:0] rdData,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              drop
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              wrAccept;
  logic              popOk;

  assign full     = (level_q == (ADDR_W+1)'(DEPTH));
  assign wrAccept = wrEn & ~full;
  assign drop     = wrEn & full;
  assign popOk    = pop & (level_q != '0);
  assign rdData   = mem_q[rdPtr_q];
  assign level    = level_q;

  // Next pointers and occupancy; a simultaneous write and pop cancel out.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrAccept) wrPtr_d = wrPtr_q + 1'b1;
    if (popOk)    rdPtr_d = rdPtr_q + 1'b1;
    case ({wrAccept, popOk})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wrAccept) mem_q[wrPtr_q] <= wData;
  end

endmodule

// File: rtl/word_packer.sv
// Buffers 12-bit channel words and emits each pair as three bytes over a
// valid/ready link. Bytes are held stable until accepted; lost writes set a
// sticky overflow flag.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] wData,
  input  logic              wrEn,
  output logic [BYTE_W-1:0] txData,
  output logic              txValid,
  input  logic              txReady,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              overflow
);

  packState_e        state_q, state_d;
  logic [WORD_W-1:0] wordA_q, wordA_d;
  logic [WORD_W-1:0] wordB_q, wordB_d;
  logic [BYTE_W-1:0] txData_q, txData_d;
  logic              txValid_q, txValid_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic              drop;
  logic [WORD_W-1:0] rdData;

  word_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wData  (wData),
    .wrEn   (wrEn),
    .pop    (pop),
    .rdData (rdData),
    .level  (level),
    .full   (full),
    .drop   (drop)
  );

  assign txData   = txData_q;
  assign txValid  = txValid_q;
  assign overflow = overflow_q;

  // Packer sequencing: pop a pair, then walk the three bytes out under txReady.
  always_comb begin
    state_d    = state_q;
    wordA_d    = wordA_q;
    wordB_d    = wordB_q;
    txData_d   = txData_q;
    txValid_d  = txValid_q;
    overflow_d = overflow_q | drop;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level >= (ADDR_W+1)'(2)) begin
          wordA_d = rdData;
          pop     = 1'b1;
          state_d = POP_B;
        end
      end
      POP_B: begin
        wordB_d   = rdData;
        pop       = 1'b1;
        txData_d  = pairByte(wordA_q, rdData, 2'd0);
        txValid_d = 1'b1;
        state_d   = BYTE0;
      end
      BYTE0: begin
        if (txReady) begin
          txData_d = pairByte(wordA_q, wordB_q, 2'd1);
          state_d  = BYTE1;
        end
      end
      BYTE1: begin
        if (txReady) begin
          txData_d = pairByte(wordA_q, wordB_q, 2'd2);
          state_d  = BYTE2;
        end
      end
      BYTE2: begin
        if (txReady) begin
          txValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packer state, pair holding registers, output byte and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wordA_q    <= '0;
      wordB_q    <= '0;
      txData_q   <= '0;
      txValid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordA_q    <= wordA_d;
      wordB_q    <= wordB_d;
      txData_q   <= txData_d;
      txValid_q  <= txValid_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: accepted words are paired by a simple
// model and their bytes queued; a monitor pops and compares every transfer.
module tb_word_packer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   wData;
  logic          wrEn;
  logic [7:0]    txData;
  logic          txValid;
  logic          txReady;
  logic [ADDR_W:0] level;
  logic          full;
  logic          overflow;

  int            checks = 0;
  int            fails  = 0;
  logic [7:0]    expQ[$];
  logic [11:0]   pendWord;
  bit            havePend = 0;
  bit            held = 0;
  logic [7:0]    heldData;

  word_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .wData    (wData),
    .wrEn     (wrEn),
    .txData   (txData),
    .txValid  (txValid),
    .txReady  (txReady),
    .level    (level),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Two words make a 24-bit group sent most significant byte first.
  task automatic pushPair(input logic [11:0] a, input logic [11:0] b);
    int p;
    p = int'(a) * 4096 + int'(b);
    expQ.push_back(8'(p / 65536));
    expQ.push_back(8'((p / 256) % 256));
    expQ.push_back(8'(p % 256));
  endtask

  task automatic applyStimulus(input logic [11:0] w, input bit accepted);
    wData = w;
    wrEn  = 1'b1;
    @(posedge clk); #1;
    wrEn  = 1'b0;
    if (accepted) begin
      if (havePend) begin
        pushPair(pendWord, w);
        havePend = 0;
      end else begin
        pendWord = w;
        havePend = 1;
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    expQ.delete();
    havePend = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || txValid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain expected bytes", expQ.size(), 0);
    checkOutput("drain txValid low", txValid, 0);
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!txValid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("txValid rises", txValid, 1);
  endtask

  // Monitor: inspect at the falling edge what the next rising edge will see.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("held txValid", txValid, 1);
          checkOutput("held txData stable", txData, heldData);
        end
        if (txValid && txReady) begin
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected byte: got 0x%0h, expected none at %0t", txData, $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("byte stream", txData, e);
          end
          held = 0;
        end else if (txValid) begin
          held     = 1;
          heldData = txData;
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin
    wData   = '0;
    wrEn    = 1'b0;
    txReady = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset txData", txData, 0);
    checkOutput("reset txValid", txValid, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset overflow", overflow, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic pair with exact latency.
    $display("[TB] basic pair 0xABC 0x123");
    txReady = 1'b1;
    applyStimulus(12'hABC, 1);
    applyStimulus(12'h123, 1);
    checkOutput("latency N txValid", txValid, 0);
    @(posedge clk); #1;
    checkOutput("latency N+1 txValid", txValid, 0);
    checkOutput("latency N+1 level", level, 1);
    @(posedge clk); #1;
    checkOutput("latency N+2 txValid", txValid, 1);
    checkOutput("latency N+2 byte0", txData, 8'hAB);
    checkOutput("latency N+2 level", level, 0);
    @(posedge clk); #1;
    checkOutput("latency N+3 byte1", txData, 8'hC1);
    @(posedge clk); #1;
    checkOutput("latency N+4 byte2", txData, 8'h23);
    @(posedge clk); #1;
    checkOutput("latency N+5 txValid", txValid, 0);
    waitDrain(10);

    // A lone word never starts a pair.
    $display("[TB] single word waits");
    applyStimulus(12'h5A5, 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("single level", level, 1);
    checkOutput("single txValid", txValid, 0);
    doReset();

    // Stalled sink holds the first byte.
    $display("[TB] stall pair 0xFFF 0x000");
    txReady = 1'b0;
    applyStimulus(12'hFFF, 1);
    applyStimulus(12'h000, 1);
    waitValid(10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall txData", txData, 8'hFF);
      checkOutput("stall level", level, 0);
    end
    txReady = 1'b1;
    waitDrain(20);

    // Overflow: one pair is absorbed into the packer, then 16 words fill the FIFO.
    $display("[TB] overflow");
    doReset();
    txReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(12'($urandom_range(0, 4095)), i < 18);
    end
    checkOutput("overflow full", full, 1);
    checkOutput("overflow level", level, DEPTH);
    checkOutput("overflow flag", overflow, 1);
    txReady = 1'b1;
    waitDrain(300);
    checkOutput("overflow sticky", overflow, 1);
    checkOutput("overflow drained level", level, 0);
    checkOutput("overflow drained full", full, 0);

    // Incrementing words across the pointer wrap with a random sink.
    $display("[TB] random ready stream");
    doReset();
    checkOutput("overflow cleared by reset", overflow, 0);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          applyStimulus(12'(i), 1);
          repeat (5) @(posedge clk);
          #1;
        end
      end
      begin
        repeat (260) begin
          txReady = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        txReady = 1'b1;
      end
    join
    waitDrain(400);
    checkOutput("stream overflow", overflow, 0);
    checkOutput("stream level", level, 0);

    // Reset while the second byte is pending.
    $display("[TB] reset during second byte");
    txReady = 1'b0;
    applyStimulus(12'h321, 1);
    applyStimulus(12'h654, 1);
    waitValid(10);
    txReady = 1'b1;
    @(posedge clk); #1;
    txReady = 1'b0;
    checkOutput("pending byte1", txData, 8'h16);
    reset = 1'b0;
    expQ.delete();
    havePend = 0;
    #1;
    checkOutput("async reset txValid", txValid, 0);
    checkOutput("async reset txData", txData, 0);
    @(posedge clk); #1;
    checkOutput("reset level", level, 0);
    checkOutput("reset txValid held", txValid, 0);
    @(posedge clk); #1;
    reset   = 1'b1;
    txReady = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no bytes after reset", txValid, 0);
    applyStimulus(12'h111, 1);
    applyStimulus(12'h222, 1);
    waitDrain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
